// File: rtl/rename_stage_if.sv
// rename_stage_if: rename group in/out handshakes plus completion, commit, flush and free-count side bands.
interface rename_stage_if #(
    parameter int WIDTH     = 4,
    parameter int ARCH_REGS = 10,
    parameter int PHYS_REGS = 32,
    parameter int CMPLT_W   = 6,
    parameter int COMMIT_W  = 4,
    parameter int PAY_W     = 24
);
    localparam int ARCH_W = $clog2(ARCH_REGS);
    localparam int PR_W   = $clog2(PHYS_REGS);
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_lane_v;
    logic [WIDTH-1:0]          in_dst_en;
    logic [WIDTH*ARCH_W-1:0]   in_dst;
    logic [WIDTH*ARCH_W-1:0]   in_src0;
    logic [WIDTH*ARCH_W-1:0]   in_src1;
    logic [WIDTH*PAY_W-1:0]    in_pay;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_lane_v;
    logic [WIDTH*PAY_W-1:0]    out_pay;
    logic [WIDTH*PR_W-1:0]     out_pdst;
    logic [WIDTH*PR_W-1:0]     out_pold;
    logic [WIDTH*PR_W-1:0]     out_psrc0;
    logic [WIDTH*PR_W-1:0]     out_psrc1;
    logic [WIDTH-1:0]          out_rdy0;
    logic [WIDTH-1:0]          out_rdy1;
    logic [CMPLT_W-1:0]        cmplt_v;
    logic [CMPLT_W*PR_W-1:0]   cmplt_preg;
    logic [COMMIT_W-1:0]       commit_v;
    logic [COMMIT_W*ARCH_W-1:0] commit_arch;
    logic [COMMIT_W*PR_W-1:0]  commit_pnew;
    logic [COMMIT_W*PR_W-1:0]  commit_pold;
    logic                      flush;
    logic [PR_W:0]             free_cnt;

    modport master (
        output in_valid, in_lane_v, in_dst_en, in_dst, in_src0, in_src1, in_pay, out_ready,
               cmplt_v, cmplt_preg, commit_v, commit_arch, commit_pnew, commit_pold, flush,
        input  in_ready, out_valid, out_lane_v, out_pay, out_pdst, out_pold, out_psrc0, out_psrc1,
               out_rdy0, out_rdy1, free_cnt
    );
    modport slave (
        input  in_valid, in_lane_v, in_dst_en, in_dst, in_src0, in_src1, in_pay, out_ready,
               cmplt_v, cmplt_preg, commit_v, commit_arch, commit_pnew, commit_pold, flush,
        output in_ready, out_valid, out_lane_v, out_pay, out_pdst, out_pold, out_psrc0, out_psrc1,
               out_rdy0, out_rdy1, free_cnt
    );
endinterface

// File: rtl/rename_stage.sv
// rename_stage: register renaming with speculative/architectural RATs, free and ready bitmaps, one output register.
module rename_stage #(
    parameter int WIDTH     = 4,
    parameter int ARCH_REGS = 10,
    parameter int PHYS_REGS = 32,
    parameter int CMPLT_W   = 6,
    parameter int COMMIT_W  = 4,
    parameter int PAY_W     = 24
) (
    input logic clk,
    input logic rst,
    rename_stage_if.slave bus
);
    localparam int ARCH_W = $clog2(ARCH_REGS);
    localparam int PR_W   = $clog2(PHYS_REGS);
    typedef logic [PR_W-1:0]   preg_t;
    typedef logic [ARCH_W-1:0] areg_t;

    preg_t srat_q [ARCH_REGS];
    preg_t arat_q [ARCH_REGS];
    preg_t srat_n [ARCH_REGS];
    preg_t arat_n [ARCH_REGS];
    preg_t ren    [ARCH_REGS];
    logic [PHYS_REGS-1:0] free_q, rdy_q, free_n, rdy_n, free_ren, cdone, alloc, mapped;
    logic [ARCH_REGS-1:0] fwd;
    logic [WIDTH*PR_W-1:0] pdst, pold, psrc0, psrc1;
    logic [WIDTH-1:0] rdy0, rdy1;
    logic [PR_W:0] need, free_cnt;
    logic in_rdy, accept, found;
    areg_t a0, a1, d;
    preg_t p;
    logic ov_q;
    logic [WIDTH-1:0] lane_v_q, rdy0_q, rdy1_q;
    logic [WIDTH*PAY_W-1:0] pay_q;
    logic [WIDTH*PR_W-1:0] pdst_q, pold_q, psrc0_q, psrc1_q;

    function automatic logic in_arch(input areg_t a);
        return int'(a) < ARCH_REGS;
    endfunction

    function automatic preg_t look(input preg_t t [ARCH_REGS], input areg_t a);
        return in_arch(a) ? t[a] : '0;
    endfunction

    assign need     = (PR_W+1)'($countones(bus.in_lane_v & bus.in_dst_en));
    assign free_cnt = (PR_W+1)'($countones(free_q));
    assign in_rdy   = !bus.flush && need <= free_cnt && (!ov_q || bus.out_ready);
    assign accept   = bus.in_valid && in_rdy;

    always_comb begin
        cdone = '0;
        for (int k = 0; k < CMPLT_W; k++)
            if (bus.cmplt_v[k]) cdone[bus.cmplt_preg[k*PR_W +: PR_W]] = 1'b1;
    end

    // Lanes are walked in order against a running copy of the SRAT, so later lanes see earlier renames.
    always_comb begin
        ren = srat_q;
        free_ren = free_q;
        fwd = '0;
        pdst = '0;
        pold = '0;
        psrc0 = '0;
        psrc1 = '0;
        rdy0 = '0;
        rdy1 = '0;
        a0 = '0;
        a1 = '0;
        d = '0;
        p = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            a0 = bus.in_src0[i*ARCH_W +: ARCH_W];
            a1 = bus.in_src1[i*ARCH_W +: ARCH_W];
            d  = bus.in_dst[i*ARCH_W +: ARCH_W];
            if (bus.in_lane_v[i]) begin
                psrc0[i*PR_W +: PR_W] = look(ren, a0);
                psrc1[i*PR_W +: PR_W] = look(ren, a1);
                rdy0[i] = !(in_arch(a0) && fwd[a0]) && (rdy_q[look(ren, a0)] || cdone[look(ren, a0)]);
                rdy1[i] = !(in_arch(a1) && fwd[a1]) && (rdy_q[look(ren, a1)] || cdone[look(ren, a1)]);
                if (bus.in_dst_en[i]) begin
                    found = 1'b0;
                    p = '0;
                    for (int j = 0; j < PHYS_REGS; j++)
                        if (!found && free_ren[j]) begin
                            found = 1'b1;
                            p = PR_W'(j);
                        end
                    pold[i*PR_W +: PR_W] = look(ren, d);
                    pdst[i*PR_W +: PR_W] = p;
                    free_ren[p] = 1'b0;
                    if (in_arch(d)) begin
                        ren[d] = p;
                        fwd[d] = 1'b1;
                    end
                end
            end
        end
    end

    // Commit frees land in free_q only next cycle; allocation already used the registered bitmap.
    always_comb begin
        arat_n = arat_q;
        srat_n = srat_q;
        free_n = free_q;
        rdy_n = rdy_q | cdone;
        mapped = '0;
        alloc = free_q & ~free_ren;
        for (int k = 0; k < COMMIT_W; k++)
            if (bus.commit_v[k]) begin
                if (in_arch(bus.commit_arch[k*ARCH_W +: ARCH_W]))
                    arat_n[bus.commit_arch[k*ARCH_W +: ARCH_W]] = bus.commit_pnew[k*PR_W +: PR_W];
                free_n[bus.commit_pold[k*PR_W +: PR_W]] = 1'b1;
            end
        if (accept) begin
            srat_n = ren;
            free_n = free_n & ~alloc;
            rdy_n = rdy_n & ~alloc;
        end
        for (int a = 0; a < ARCH_REGS; a++) mapped[arat_n[a]] = 1'b1;
        if (bus.flush) begin
            srat_n = arat_n;
            free_n = ~mapped;
            rdy_n = rdy_n | mapped;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                srat_q[i] <= PR_W'(i);
                arat_q[i] <= PR_W'(i);
            end
            free_q <= {PHYS_REGS{1'b1}} << ARCH_REGS;
            rdy_q <= '1;
            ov_q <= 1'b0;
            lane_v_q <= '0;
            pay_q <= '0;
            pdst_q <= '0;
            pold_q <= '0;
            psrc0_q <= '0;
            psrc1_q <= '0;
            rdy0_q <= '0;
            rdy1_q <= '0;
        end else begin
            srat_q <= srat_n;
            arat_q <= arat_n;
            free_q <= free_n;
            rdy_q <= rdy_n;
            ov_q <= !bus.flush && (accept || (ov_q && !bus.out_ready));
            if (accept) begin
                lane_v_q <= bus.in_lane_v;
                pay_q <= bus.in_pay;
                pdst_q <= pdst;
                pold_q <= pold;
                psrc0_q <= psrc0;
                psrc1_q <= psrc1;
                rdy0_q <= rdy0;
                rdy1_q <= rdy1;
            end
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.free_cnt   = free_cnt;
    assign bus.out_valid  = ov_q;
    assign bus.out_lane_v = lane_v_q;
    assign bus.out_pay    = pay_q;
    assign bus.out_pdst   = pdst_q;
    assign bus.out_pold   = pold_q;
    assign bus.out_psrc0  = psrc0_q;
    assign bus.out_psrc1  = psrc1_q;
    assign bus.out_rdy0   = rdy0_q;
    assign bus.out_rdy1   = rdy1_q;
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: random rename traffic against an array/queue reference model with a scoreboard monitor.
module tb_rename_stage;
    localparam int W = 4, AR = 10, PR = 32, CW = 6, KW = 4, PW = 24, AW = 4, RW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rename_stage_if bus ();
    rename_stage dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [W-1:0] lv;
        logic [W*RW-1:0] pdst, pold, ps0, ps1;
        logic [W-1:0] r0, r1;
        logic [W*PW-1:0] pay;
    } exp_t;
    typedef struct packed {
        logic [AW-1:0] a;
        logic [RW-1:0] pn, po;
    } rob_t;

    exp_t expq[$];
    rob_t rob[$];
    int smap[AR], amap[AR];
    bit free_m[PR], rdy_m[PR];
    bit m_ov;
    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nfree();
        int n = 0;
        foreach (free_m[q]) n += int'(free_m[q]);
        return n;
    endfunction

    function automatic bit hit(int p);
        for (int k = 0; k < CW; k++)
            if (bus.cmplt_v[k] && int'(bus.cmplt_preg[k*RW +: RW]) == p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < AR; a++) begin
            smap[a] = a;
            amap[a] = a;
        end
        for (int q = 0; q < PR; q++) begin
            free_m[q] = q >= AR;
            rdy_m[q] = 1'b1;
        end
        m_ov = 1'b0;
        expq.delete();
        rob.delete();
    endtask

    task automatic model_step();
        int need;
        bit rdy_exp, acc;
        exp_t e;
        bit wr[AR];
        int alloc[$];
        need = $countones(bus.in_lane_v & bus.in_dst_en);
        rdy_exp = !bus.flush && need <= nfree() && (!m_ov || bus.out_ready);
        chk("free_cnt", bus.free_cnt, nfree());
        chk("out_valid", bus.out_valid, m_ov);
        chk("in_ready", bus.in_ready, rdy_exp);
        acc = bus.in_valid && rdy_exp;
        foreach (wr[a]) wr[a] = 1'b0;
        if (acc) begin
            e = '0;
            e.lv = bus.in_lane_v;
            e.pay = bus.in_pay;
            for (int i = 0; i < W; i++) begin
                if (bus.in_lane_v[i]) begin
                    int s0 = int'(bus.in_src0[i*AW +: AW]);
                    int s1 = int'(bus.in_src1[i*AW +: AW]);
                    int d = int'(bus.in_dst[i*AW +: AW]);
                    e.ps0[i*RW +: RW] = RW'(smap[s0]);
                    e.ps1[i*RW +: RW] = RW'(smap[s1]);
                    e.r0[i] = !wr[s0] && (rdy_m[smap[s0]] || hit(smap[s0]));
                    e.r1[i] = !wr[s1] && (rdy_m[smap[s1]] || hit(smap[s1]));
                    if (bus.in_dst_en[i]) begin
                        int p = 0;
                        while (!free_m[p]) p++;
                        e.pold[i*RW +: RW] = RW'(smap[d]);
                        e.pdst[i*RW +: RW] = RW'(p);
                        rob.push_back('{a: AW'(d), pn: RW'(p), po: RW'(smap[d])});
                        free_m[p] = 1'b0;
                        smap[d] = p;
                        wr[d] = 1'b1;
                        alloc.push_back(p);
                    end
                end
            end
            expq.push_back(e);
        end
        for (int k = 0; k < CW; k++)
            if (bus.cmplt_v[k]) rdy_m[bus.cmplt_preg[k*RW +: RW]] = 1'b1;
        foreach (alloc[j]) rdy_m[alloc[j]] = 1'b0;
        for (int k = 0; k < KW; k++)
            if (bus.commit_v[k]) begin
                amap[bus.commit_arch[k*AW +: AW]] = int'(bus.commit_pnew[k*RW +: RW]);
                free_m[bus.commit_pold[k*RW +: RW]] = 1'b1;
                if (rob.size() > 0) void'(rob.pop_front());
            end
        if (bus.flush) begin
            smap = amap;
            foreach (free_m[q]) free_m[q] = 1'b1;
            for (int a = 0; a < AR; a++) begin
                free_m[amap[a]] = 1'b0;
                rdy_m[amap[a]] = 1'b1;
            end
            rob.delete();
            expq.delete();
            m_ov = 1'b0;
        end else begin
            m_ov = acc ? 1'b1 : (m_ov && !bus.out_ready);
        end
    endtask

    // Model runs just after the monitor so a group handed off in a flush cycle is consumed first.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            model_reset();
            chk("reset free_cnt", bus.free_cnt, 22);
            chk("reset out_valid", bus.out_valid, 0);
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out_group: got an output group, expected none at %0t", $time);
            end else begin
                exp_t e;
                logic [W*RW-1:0] m;
                e = expq.pop_front();
                m = '0;
                for (int i = 0; i < W; i++) if (e.lv[i]) m[i*RW +: RW] = '1;
                chk("out_lane_v", bus.out_lane_v, e.lv);
                chk("out_pdst", bus.out_pdst, e.pdst);
                chk("out_pold", bus.out_pold, e.pold);
                chk("out_psrc0", bus.out_psrc0 & m, e.ps0 & m);
                chk("out_psrc1", bus.out_psrc1 & m, e.ps1 & m);
                chk("out_rdy0", bus.out_rdy0 & e.lv, e.r0 & e.lv);
                chk("out_rdy1", bus.out_rdy1 & e.lv, e.r1 & e.lv);
                chk("out_pay", bus.out_pay, e.pay);
            end
        end
    end

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_lane_v = '0;
        bus.in_dst_en = '0;
        bus.in_dst = '0;
        bus.in_src0 = '0;
        bus.in_src1 = '0;
        bus.in_pay = '0;
        bus.out_ready = 1'b1;
        bus.cmplt_v = '0;
        bus.cmplt_preg = '0;
        bus.commit_v = '0;
        bus.commit_arch = '0;
        bus.commit_pnew = '0;
        bus.commit_pold = '0;
        bus.flush = 1'b0;
    endtask

    task automatic drive_random(input int c);
        int n, kmax, k;
        bit heavy;
        idle();
        bus.in_valid = $urandom_range(0, 3) != 0;
        n = $urandom_range(0, W);
        bus.in_lane_v = W'((1 << n) - 1);
        bus.in_dst_en = W'($urandom);
        for (int i = 0; i < W; i++) begin
            bus.in_dst[i*AW +: AW] = AW'($urandom_range(0, AR - 1));
            bus.in_src0[i*AW +: AW] = AW'($urandom_range(0, AR - 1));
            bus.in_src1[i*AW +: AW] = AW'($urandom_range(0, AR - 1));
        end
        bus.in_pay = {$urandom, $urandom, $urandom};
        bus.out_ready = $urandom_range(0, 9) < 7;
        bus.flush = $urandom_range(0, 59) == 0;
        // Alternate commit-starved and commit-rich stretches so the free list both drains and refills.
        heavy = (c % 400) >= 150;
        kmax = rob.size() < KW ? rob.size() : KW;
        k = heavy ? $urandom_range(0, kmax) : (($urandom_range(0, 9) == 0 && kmax > 0) ? 1 : 0);
        for (int i = 0; i < k; i++) begin
            bus.commit_v[i] = 1'b1;
            bus.commit_arch[i*AW +: AW] = rob[i].a;
            bus.commit_pnew[i*RW +: RW] = rob[i].pn;
            bus.commit_pold[i*RW +: RW] = rob[i].po;
        end
        for (int i = 0; i < CW; i++)
            if (rob.size() > 0 && $urandom_range(0, 2) == 0) begin
                bus.cmplt_v[i] = 1'b1;
                bus.cmplt_preg[i*RW +: RW] = rob[$urandom_range(0, rob.size() - 1)].pn;
            end
    endtask

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_lane_v = 4'b1111;
        bus.in_dst_en = 4'b1111;
        bus.in_dst = {4'd4, 4'd3, 4'd2, 4'd1};
        bus.in_pay = {$urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        bus.in_lane_v = 4'b0011;
        bus.in_dst_en = 4'b0001;
        bus.in_dst = 16'h0005;
        bus.in_src0 = 16'h0050;
        bus.in_src1 = '0;
        @(negedge clk);
        chk("first pdst", bus.out_pdst, {5'd13, 5'd12, 5'd11, 5'd10});
        chk("first pold", bus.out_pold, {5'd4, 5'd3, 5'd2, 5'd1});
        chk("first free_cnt", bus.free_cnt, 18);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        chk("fwd pdst lane0", bus.out_pdst[4:0], 14);
        chk("fwd psrc0 lane1", bus.out_psrc0[9:5], 14);
        chk("fwd rdy0 lane1", bus.out_rdy0[1], 0);
        chk("fwd free_cnt", bus.free_cnt, 17);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (c == 1500 || c == 1501) begin
                rst = 1'b0;
                idle();
            end else begin
                rst = 1'b1;
                drive_random(c);
            end
        end
        @(posedge clk);
        #1;
        idle();
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("drain scoreboard", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
